// File: rtl/icap_pkg.sv
// Shared constants, header field positions and state encoding for the ICAP responder model.
package icap_pkg;

    localparam logic [31:0] SYNC_WORD  = 32'hAA995566;
    localparam logic [31:0] NOOP_WORD  = 32'h20000000;
    localparam logic [31:0] DUMMY_WORD = 32'hFFFFFFFF;

    localparam int TYPE_MSB  = 31;
    localparam int TYPE_LSB  = 29;
    localparam int OP_MSB    = 28;
    localparam int OP_LSB    = 27;
    localparam int ADDR_MSB  = 17;
    localparam int ADDR_LSB  = 13;
    localparam int WC_MSB    = 10;
    localparam int WC_LSB    = 0;
    localparam int T2CNT_MSB = 26;
    localparam int T2CNT_LSB = 0;

    localparam logic [2:0] HDR_TYPE1 = 3'b001;
    localparam logic [2:0] HDR_TYPE2 = 3'b010;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;

    localparam logic [4:0] REG_FDRI   = 5'd2;
    localparam logic [4:0] REG_FDRO   = 5'd3;
    localparam logic [4:0] REG_CMD    = 5'd4;
    localparam logic [4:0] REG_IDCODE = 5'd12;
    localparam logic [4:0] CMD_DESYNC = 5'h0D;

    typedef enum logic [2:0] {
        ST_DESYNC,
        ST_IDLE,
        ST_WR_DATA,
        ST_RD_WAIT,
        ST_RD_DATA
    } icap_state_t;

    // Words that never carry a packet header: sync, type-1 no-op and bus dummy.
    function automatic logic isFillerWord(input logic [31:0] word);
        return (word == SYNC_WORD) || (word == NOOP_WORD) || (word == DUMMY_WORD);
    endfunction

endpackage

// File: rtl/icap_responder_model_if.sv
// ICAP host/device bus; the controller is the master, the responder model is the slave.
interface icap_responder_model_if;

    logic        icap_ce;
    logic        icap_write;
    logic [31:0] icap_data_in;
    logic [31:0] icap_data_out;
    logic        icap_busy;

    modport master (
        output icap_ce, icap_write, icap_data_in,
        input  icap_data_out, icap_busy
    );

    modport slave (
        input  icap_ce, icap_write, icap_data_in,
        output icap_data_out, icap_busy
    );

endinterface

// File: rtl/icap_cfg_regfile.sv
// 32x32 configuration register file with one write port and a registered read port
// that substitutes IDCODE and the FDRO word index at their special addresses.
module icap_cfg_regfile import icap_pkg::*; #(
    parameter logic [31:0] IDCODE = 32'h0424A093
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic        i_re,
    input  logic        i_clr,
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic [26:0] i_fdroIdx,
    output logic [31:0] o_rdata
);

    logic [31:0] r_mem [32];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Readback is held between requests; a clear forces the desynced "read returns 0".
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_clr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            if (i_addr == REG_IDCODE) begin
                r_rdata <= IDCODE;
            end else if (i_addr == REG_FDRO) begin
                r_rdata <= {5'd0, i_fdroIdx};
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/icap_responder_model.sv
// Device-side ICAP responder: sync detection, Type1/Type2 packet decode, register
// file access and readback with ICAP-style BUSY latency.
module icap_responder_model import icap_pkg::*; #(
    parameter int          ICAP_WIDTH   = 32,
    parameter logic        IS_BUSY      = 1'b0,
    parameter logic [31:0] IDCODE       = 32'h0424A093,
    parameter int          READ_LATENCY = 2
) (
    input  logic                   ICAP_clk,
    input  logic                   ICAP_reset,
    icap_responder_model_if.slave  bus,
    output logic                   synced,
    output logic                   proto_err,
    output logic [31:0]            fdri_word_count
);

    icap_state_t r_state, w_stateNext;
    logic [26:0] r_cnt, w_cntNext;
    logic [4:0]  r_addr, w_addrNext;
    logic [1:0]  r_op, w_opNext;
    logic [3:0]  r_latCnt, w_latNext;
    logic [26:0] r_rdIdx, w_rdIdxNext;
    logic        r_protoErr, w_protoErrNext;
    logic [31:0] r_fdriCnt, w_fdriNext;
    logic        r_busy, w_busyNext;

    logic [ICAP_WIDTH-1:0] w_din;
    logic        w_wrXfer, w_rdXfer;
    logic        w_isType1, w_isType2;
    logic [1:0]  w_hdrOp, w_pktOp;
    logic [26:0] w_pktCnt;
    logic        w_regWe, w_regRe, w_regClr;

    assign w_din     = bus.icap_data_in;
    assign w_wrXfer  = !bus.icap_ce && !bus.icap_write;
    assign w_rdXfer  = !bus.icap_ce && bus.icap_write;
    assign w_isType1 = (w_din[TYPE_MSB:TYPE_LSB] == HDR_TYPE1);
    assign w_isType2 = (w_din[TYPE_MSB:TYPE_LSB] == HDR_TYPE2);
    assign w_hdrOp   = w_din[OP_MSB:OP_LSB];

    // Type2 headers carry only a count and reuse the last Type1 opcode.
    assign w_pktOp  = w_isType1 ? w_hdrOp : r_op;
    assign w_pktCnt = w_isType1 ? {16'd0, w_din[WC_MSB:WC_LSB]} : w_din[T2CNT_MSB:T2CNT_LSB];

    always_ff @(posedge ICAP_clk or posedge ICAP_reset) begin
        if (ICAP_reset) begin
            r_state    <= ST_DESYNC;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_op       <= OP_NOP;
            r_latCnt   <= '0;
            r_rdIdx    <= '0;
            r_protoErr <= 1'b0;
            r_fdriCnt  <= '0;
            r_busy     <= IS_BUSY;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_addr     <= w_addrNext;
            r_op       <= w_opNext;
            r_latCnt   <= w_latNext;
            r_rdIdx    <= w_rdIdxNext;
            r_protoErr <= w_protoErrNext;
            r_fdriCnt  <= w_fdriNext;
            r_busy     <= w_busyNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_cntNext      = r_cnt;
        w_addrNext     = r_addr;
        w_opNext       = r_op;
        w_latNext      = r_latCnt;
        w_rdIdxNext    = r_rdIdx;
        w_protoErrNext = r_protoErr;
        w_fdriNext     = r_fdriCnt;
        w_regWe        = 1'b0;
        w_regRe        = 1'b0;
        w_regClr       = 1'b0;
        case (r_state)
            ST_DESYNC: begin
                if (w_wrXfer && (w_din == SYNC_WORD)) w_stateNext = ST_IDLE;
                if (w_rdXfer) w_regClr = 1'b1;
            end
            ST_IDLE: begin
                if (w_rdXfer) begin
                    w_protoErrNext = 1'b1;
                end else if (w_wrXfer && !isFillerWord(w_din)) begin
                    if (w_isType1 && (w_hdrOp == OP_RD || w_hdrOp == OP_WR)) begin
                        w_addrNext = w_din[ADDR_MSB:ADDR_LSB];
                        w_opNext   = w_hdrOp;
                    end
                    if ((w_isType1 || w_isType2) && (w_pktCnt != '0)) begin
                        if (w_pktOp == OP_WR) begin
                            w_cntNext   = w_pktCnt;
                            w_stateNext = ST_WR_DATA;
                        end else if (w_pktOp == OP_RD) begin
                            w_cntNext   = w_pktCnt;
                            w_latNext   = '0;
                            w_rdIdxNext = '0;
                            w_stateNext = ST_RD_WAIT;
                        end
                    end
                    if (!(w_isType1 || w_isType2) || (w_isType1 && w_hdrOp == 2'b11)) begin
                        w_protoErrNext = 1'b1;
                    end
                end
            end
            ST_WR_DATA: begin
                if (w_rdXfer) begin
                    w_protoErrNext = 1'b1;
                    w_cntNext      = '0;
                    w_stateNext    = ST_IDLE;
                end else if (w_wrXfer) begin
                    if (r_cnt <= 27'd1) begin
                        w_cntNext   = '0;
                        w_stateNext = ST_IDLE;
                    end else begin
                        w_cntNext = r_cnt - 27'd1;
                    end
                    if (r_addr == REG_FDRI) begin
                        w_fdriNext = r_fdriCnt + 32'd1;
                    end else if (r_addr == REG_IDCODE) begin
                        if (w_din != IDCODE) w_protoErrNext = 1'b1;
                    end else begin
                        w_regWe = 1'b1;
                        // A DESYNC command overrides the normal end-of-packet return to IDLE.
                        if ((r_addr == REG_CMD) && (w_din == {27'd0, CMD_DESYNC})) begin
                            w_cntNext   = '0;
                            w_stateNext = ST_DESYNC;
                        end
                    end
                end
            end
            ST_RD_WAIT: begin
                if (r_latCnt == '0) begin
                    if (w_rdXfer) begin
                        w_latNext = 4'(READ_LATENCY);
                    end else if (w_wrXfer && (w_din != SYNC_WORD)) begin
                        w_protoErrNext = 1'b1;
                        w_cntNext      = '0;
                        w_stateNext    = ST_IDLE;
                    end
                end else if (!bus.icap_ce) begin
                    w_latNext = r_latCnt - 4'd1;
                    if (r_latCnt == 4'd1) w_stateNext = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (w_rdXfer) begin
                    w_regRe     = 1'b1;
                    w_rdIdxNext = r_rdIdx + 27'd1;
                    if (r_cnt <= 27'd1) begin
                        w_cntNext   = '0;
                        w_stateNext = ST_IDLE;
                    end else begin
                        w_cntNext = r_cnt - 27'd1;
                    end
                end else if (w_wrXfer && (w_din != SYNC_WORD)) begin
                    w_protoErrNext = 1'b1;
                    w_cntNext      = '0;
                    w_stateNext    = ST_IDLE;
                end
            end
            default: w_stateNext = ST_DESYNC;
        endcase
        w_busyNext = ((w_stateNext == ST_RD_WAIT) && (w_latNext != '0)) ? IS_BUSY : ~IS_BUSY;
    end

    icap_cfg_regfile #(
        .IDCODE(IDCODE)
    ) u_regfile (
        .i_clk    (ICAP_clk),
        .i_rst    (ICAP_reset),
        .i_we     (w_regWe),
        .i_re     (w_regRe),
        .i_clr    (w_regClr),
        .i_addr   (r_addr),
        .i_wdata  (w_din),
        .i_fdroIdx(r_rdIdx),
        .o_rdata  (bus.icap_data_out)
    );

    assign bus.icap_busy   = r_busy;
    assign synced          = (r_state != ST_DESYNC);
    assign proto_err       = r_protoErr;
    assign fdri_word_count = r_fdriCnt;

endmodule

// File: tb/tb_icap_responder_model.sv
// Directed bench for icap_responder_model: sync, register write/readback, FDRI streaming,
// FDRO indexing, DESYNC command and asynchronous reset during a read packet.
module tb_icap_responder_model;

    localparam logic        IS_BUSY  = 1'b0;
    localparam logic [31:0] IDCODE   = 32'h0424A093;
    localparam logic [31:0] SYNC     = 32'hAA995566;
    localparam logic [31:0] NOOP     = 32'h20000000;
    // Type1 headers: {001, op, 9'b0, addr, 2'b0, wc}
    localparam logic [31:0] WR_CMD_1    = 32'h30008001;
    localparam logic [31:0] RD_CMD_1    = 32'h28008001;
    localparam logic [31:0] RD_CMD_4    = 32'h28008004;
    localparam logic [31:0] RD_IDCODE_1 = 32'h28018001;
    localparam logic [31:0] WR_IDCODE_1 = 32'h30018001;
    localparam logic [31:0] WR_FDRI_0   = 32'h30004000;
    localparam logic [31:0] WR_FDRI_1   = 32'h30004001;
    localparam logic [31:0] T2_300      = 32'h4000012C;
    localparam logic [31:0] RD_FDRO_4   = 32'h28006004;

    logic        clk = 1'b0;
    logic        rst;
    logic        synced;
    logic        protoErr;
    logic [31:0] fdriCount;
    int          testCount = 0;
    int          failCount = 0;

    icap_responder_model_if bus();

    icap_responder_model #(
        .ICAP_WIDTH  (32),
        .IS_BUSY     (IS_BUSY),
        .IDCODE      (IDCODE),
        .READ_LATENCY(2)
    ) dut (
        .ICAP_clk       (clk),
        .ICAP_reset     (rst),
        .bus            (bus),
        .synced         (synced),
        .proto_err      (protoErr),
        .fdri_word_count(fdriCount)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge; outputs are sampled at that same point.
    task automatic applyStimulus(input logic ce, input logic wr, input logic [31:0] din);
        bus.icap_ce      = ce;
        bus.icap_write   = wr;
        bus.icap_data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic writeWord(input logic [31:0] w);
        applyStimulus(1'b0, 1'b0, w);
    endtask

    task automatic readWord();
        applyStimulus(1'b0, 1'b1, 32'h0);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.icap_ce      = 1'b1;
        bus.icap_write   = 1'b0;
        bus.icap_data_in = 32'h0;
        #1;
        checkOutput("rst data_out", bus.icap_data_out, 32'h0);
        checkOutput("rst busy", {31'd0, bus.icap_busy}, {31'd0, IS_BUSY});
        checkOutput("rst synced", {31'd0, synced}, 32'd0);
        checkOutput("rst proto_err", {31'd0, protoErr}, 32'd0);
        checkOutput("rst fdri", fdriCount, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst held busy", {31'd0, bus.icap_busy}, {31'd0, IS_BUSY});
        rst = 1'b0;
        idleCycle();
        checkOutput("first clk busy", {31'd0, bus.icap_busy}, {31'd0, ~IS_BUSY});

        // 1: sync, write CMD=7, read CMD back through the busy window
        writeWord(32'h12345678);
        checkOutput("desync ignores", {31'd0, synced}, 32'd0);
        writeWord(SYNC);
        checkOutput("t1 synced", {31'd0, synced}, 32'd1);
        writeWord(WR_CMD_1);
        writeWord(32'h00000007);
        writeWord(RD_CMD_1);
        checkOutput("t1 hdr busy", {31'd0, bus.icap_busy}, {31'd0, ~IS_BUSY});
        readWord();
        checkOutput("t1 busy c1", {31'd0, bus.icap_busy}, {31'd0, IS_BUSY});
        readWord();
        checkOutput("t1 busy c2", {31'd0, bus.icap_busy}, {31'd0, IS_BUSY});
        readWord();
        checkOutput("t1 busy off", {31'd0, bus.icap_busy}, {31'd0, ~IS_BUSY});
        readWord();
        checkOutput("t1 data", bus.icap_data_out, 32'h7);
        checkOutput("t1 busy data", {31'd0, bus.icap_busy}, {31'd0, ~IS_BUSY});
        idleCycle();
        checkOutput("t1 data hold", bus.icap_data_out, 32'h7);

        // 2: IDCODE readback, then a mismatching IDCODE write
        writeWord(SYNC);
        writeWord(RD_IDCODE_1);
        repeat (3) readWord();
        readWord();
        checkOutput("t2 idcode", bus.icap_data_out, IDCODE);
        checkOutput("t2 no err", {31'd0, protoErr}, 32'd0);
        writeWord(WR_IDCODE_1);
        writeWord(32'h12345678);
        checkOutput("t2 idcode err", {31'd0, protoErr}, 32'd1);

        // 3: FDRI stream of 300 words through a Type2 header, paused mid-way
        writeWord(WR_FDRI_0);
        writeWord(T2_300);
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                checkOutput("t3 fdri mid", fdriCount, 32'd150);
                repeat (5) applyStimulus(1'b1, 1'b0, 32'hFFFF0000);
                checkOutput("t3 fdri paused", fdriCount, 32'd150);
            end
            writeWord(32'hC0DE0000 + 32'(i));
        end
        checkOutput("t3 fdri done", fdriCount, 32'd300);
        writeWord(NOOP);
        checkOutput("t3 idle after", fdriCount, 32'd300);

        // 4: fresh reset so the fifth FDRO read's protocol error is visible
        rst = 1'b1;
        #2;
        checkOutput("t4 rst err clr", {31'd0, protoErr}, 32'd0);
        checkOutput("t4 rst fdri clr", fdriCount, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        writeWord(SYNC);
        writeWord(RD_FDRO_4);
        repeat (3) readWord();
        for (int i = 0; i < 4; i++) begin
            readWord();
            checkOutput("t4 fdro idx", bus.icap_data_out, 32'(i));
        end
        checkOutput("t4 no err", {31'd0, protoErr}, 32'd0);
        readWord();
        checkOutput("t4 5th read err", {31'd0, protoErr}, 32'd1);
        checkOutput("t4 data hold", bus.icap_data_out, 32'd3);

        // 5: CMD=DESYNC drops sync; following headers are ignored
        writeWord(WR_CMD_1);
        writeWord(32'h0000000D);
        checkOutput("t5 desynced", {31'd0, synced}, 32'd0);
        writeWord(WR_FDRI_1);
        writeWord(32'h11111111);
        checkOutput("t5 fdri hold", fdriCount, 32'd0);
        checkOutput("t5 still desync", {31'd0, synced}, 32'd0);
        readWord();
        checkOutput("t5 desync read", bus.icap_data_out, 32'd0);
        checkOutput("t5 desync busy", {31'd0, bus.icap_busy}, {31'd0, ~IS_BUSY});

        // 6: asynchronous reset in RD_DATA with three words still to go
        writeWord(SYNC);
        writeWord(RD_CMD_4);
        repeat (3) readWord();
        readWord();
        checkOutput("t6 cmd read", bus.icap_data_out, 32'h0000000D);
        rst = 1'b1;
        #2;
        checkOutput("t6 async synced", {31'd0, synced}, 32'd0);
        checkOutput("t6 async busy", {31'd0, bus.icap_busy}, {31'd0, IS_BUSY});
        checkOutput("t6 async data", bus.icap_data_out, 32'd0);
        checkOutput("t6 async err", {31'd0, protoErr}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycle();
        checkOutput("t6 busy release", {31'd0, bus.icap_busy}, {31'd0, ~IS_BUSY});
        readWord();
        checkOutput("t6 read after", bus.icap_data_out, 32'd0);
        checkOutput("t6 read busy", {31'd0, bus.icap_busy}, {31'd0, ~IS_BUSY});
        writeWord(SYNC);
        writeWord(RD_CMD_1);
        repeat (3) readWord();
        readWord();
        checkOutput("t6 cmd cleared", bus.icap_data_out, 32'd0);
        checkOutput("t6 synced", {31'd0, synced}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
